// File: rtl/bcd_formatter.sv
// Binary-to-BCD display formatter.
// Converts a W-bit candidate to 8 decimal digits by shift-add-3, blanks leading zeros and
// packs the digits with a status nibble into the 36-bit word scanned by the display driver.
// The output word only changes in the single WRITE cycle, so partial results never show.
module bcd_formatter #(
  parameter int unsigned W = 27
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [W-1:0] value,
  input  logic         is_prime,
  output logic [35:0]  ram,
  output logic         busy,
  output logic         done
);

  typedef enum logic [1:0] {
    StIdle,
    StConv,
    StBlank,
    StWrite
  } state_e;

  localparam logic [4:0]  CntConvLast  = 5'(W - 1);
  localparam logic [4:0]  CntBlankLast = 5'd6;
  localparam logic [31:0] MaxDisplay   = 32'd99_999_999;
  localparam logic [35:0] RamReset     = 36'h0_FFFF_FFFF;

  state_e        state_q, state_d;
  logic [W-1:0]  shreg_q, shreg_d;
  logic [31:0]   bcd_q, bcd_d;
  logic [4:0]    cnt_q, cnt_d;
  logic          prime_q, prime_d;
  logic          ovf_q, ovf_d;
  logic          lead_q, lead_d;
  logic [35:0]   ram_q, ram_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic [1:0]    rst_sync_q;
  logic          run_en;
  logic [31:0]   bcd_adj;
  logic [2:0]    blank_idx;
  logic [3:0]    blank_nib;

  // Reset deassertion synchronizer; assertion stays asynchronous.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rst_sync_q <= 2'b00;
    end else begin
      rst_sync_q <= {rst_sync_q[0], 1'b1};
    end
  end

  assign run_en = rst_sync_q[1];

  // Add 3 to every BCD nibble that is 5 or more before the next doubling.
  always_comb begin
    bcd_adj = bcd_q;
    for (int i = 0; i < 8; i++) begin
      if (bcd_q[4*i +: 4] >= 4'd5) begin
        bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
      end
    end
  end

  // Blank scan walks digit 7 down to digit 1.
  assign blank_idx = 3'd7 - cnt_q[2:0];
  assign blank_nib = bcd_q[{blank_idx, 2'b00} +: 4];

  // Next-state and datapath control.
  always_comb begin
    state_d = state_q;
    shreg_d = shreg_q;
    bcd_d   = bcd_q;
    cnt_d   = cnt_q;
    prime_d = prime_q;
    ovf_d   = ovf_q;
    lead_d  = lead_q;
    ram_d   = ram_q;
    done_d  = 1'b0;
    // busy follows the state one edge later and drops together with the ram update.
    busy_d  = (state_q != StIdle) && (state_q != StWrite);

    unique case (state_q)
      StIdle: begin
        if (start && run_en) begin
          shreg_d = value;
          prime_d = is_prime;
          bcd_d   = '0;
          cnt_d   = '0;
          ovf_d   = ({{(32 - W){1'b0}}, value} > MaxDisplay);
          lead_d  = 1'b1;
          state_d = StConv;
        end
      end

      StConv: begin
        bcd_d   = {bcd_adj[30:0], shreg_q[W-1]};
        shreg_d = {shreg_q[W-2:0], 1'b0};
        if (cnt_q == CntConvLast) begin
          cnt_d   = '0;
          state_d = StBlank;
        end else begin
          cnt_d = cnt_q + 5'd1;
        end
      end

      StBlank: begin
        // Leading zeros become 0xF until the first nonzero digit is seen.
        if (lead_q && (blank_nib == 4'h0)) begin
          bcd_d[{blank_idx, 2'b00} +: 4] = 4'hF;
        end else begin
          lead_d = 1'b0;
        end
        if (cnt_q == CntBlankLast) begin
          cnt_d   = '0;
          state_d = StWrite;
        end else begin
          cnt_d = cnt_q + 5'd1;
        end
      end

      StWrite: begin
        ram_d   = {prime_q, 1'b1, ovf_q, 1'b0, (ovf_q ? 32'hCCCC_CCCC : bcd_q)};
        done_d  = 1'b1;
        state_d = StIdle;
      end

      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // State and datapath registers; reset discards any conversion in progress.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= StIdle;
      shreg_q <= '0;
      bcd_q   <= '0;
      cnt_q   <= '0;
      prime_q <= 1'b0;
      ovf_q   <= 1'b0;
      lead_q  <= 1'b0;
      ram_q   <= RamReset;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      shreg_q <= shreg_d;
      bcd_q   <= bcd_d;
      cnt_q   <= cnt_d;
      prime_q <= prime_d;
      ovf_q   <= ovf_d;
      lead_q  <= lead_d;
      ram_q   <= ram_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign ram  = ram_q;
  assign busy = busy_q;
  assign done = done_q;

endmodule
